pll_lock_sequencer: RTL and testbench

Controller that sequences a PLL wrapper instance: drives its reset, supervises its locked output, and gates the system reset of the derived clock domain. Runs on the free-running board reference clock (50 MHz). Applies a timed PLL reset pulse, waits for lock with a timeout, and requires lock to be stable before releasing the downstream reset. Retries bounded times, then latches a fault; counts lock losses for debug.

---
 rtl/pll_lock_sequencer_if.sv | 22 ++
 rtl/pll_lock_sequencer.sv | 158 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pll_lock_sequencer_if.sv
// Control and status signals between the PLL lock sequencer and its supervisor/PLL wrapper.
interface pll_lock_sequencer_if;
    logic       enable;
    logic       relock_req;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       pll_ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    modport master (
        output enable, relock_req, pll_locked,
        input  pll_rst, sys_rst, pll_ready, fault, retry_cnt, loss_cnt
    );

    modport slave (
        input  enable, relock_req, pll_locked,
        output pll_rst, sys_rst, pll_ready, fault, retry_cnt, loss_cnt
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, waits for a stable lock with timeout and bounded retries,
// and gates the derived-domain reset. Runs entirely on refclk.
module pll_lock_sequencer #(
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT    = 50000,
    parameter int unsigned LOCK_STABLE     = 1024,
    parameter int unsigned MAX_RETRIES     = 3,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                 refclk,
    input  logic                 rst,
    pll_lock_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STAB_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       RETRY_LAST = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESET_PLL = 3'd1,
        WAIT_LOCK = 3'd2,
        STABILIZE = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_t;

    // Output pattern per state: {pll_rst, sys_rst, pll_ready, fault}
    function automatic logic [3:0] flags_of(input state_t s);
        case (s)
            IDLE, RESET_PLL:      flags_of = 4'b1100;
            WAIT_LOCK, STABILIZE: flags_of = 4'b0100;
            RUN:                  flags_of = 4'b0010;
            FAULT:                flags_of = 4'b1101;
            default:              flags_of = 4'b1100;
        endcase
    endfunction

    state_t           state;
    logic [3:0]       flags;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] stab_cnt;
    logic [3:0]       retry_cnt;
    logic [7:0]       loss_cnt;
    logic             lock_meta;
    logic             lock_s;

    // Two-flop synchronizer for the asynchronous PLL lock indication
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= bus.pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // Sequencer; outputs are registered together with the state they belong to
    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= IDLE;
            flags     <= flags_of(IDLE);
            hold_cnt  <= '0;
            tmo_cnt   <= '0;
            stab_cnt  <= '0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
        end else if (!bus.enable) begin
            state <= IDLE;
            flags <= flags_of(IDLE);
        end else if (bus.relock_req && (state != IDLE)) begin
            state     <= RESET_PLL;
            flags     <= flags_of(RESET_PLL);
            retry_cnt <= '0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state     <= RESET_PLL;
                    flags     <= flags_of(RESET_PLL);
                    retry_cnt <= '0;
                    hold_cnt  <= '0;
                end
                RESET_PLL: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state   <= WAIT_LOCK;
                        flags   <= flags_of(WAIT_LOCK);
                        tmo_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_ONE;
                    end
                end
                WAIT_LOCK, STABILIZE: begin
                    // Timeout spans both states and beats a simultaneous stable-lock completion
                    if (tmo_cnt == TMO_LAST) begin
                        if (retry_cnt == RETRY_LAST) begin
                            state <= FAULT;
                            flags <= flags_of(FAULT);
                        end else begin
                            retry_cnt <= retry_cnt + 4'd1;
                            state     <= RESET_PLL;
                            flags     <= flags_of(RESET_PLL);
                            hold_cnt  <= '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_ONE;
                        if (state == WAIT_LOCK) begin
                            if (lock_s) begin
                                state    <= STABILIZE;
                                flags    <= flags_of(STABILIZE);
                                stab_cnt <= '0;
                            end
                        end else if (!lock_s) begin
                            state    <= WAIT_LOCK;
                            flags    <= flags_of(WAIT_LOCK);
                            stab_cnt <= '0;
                        end else if (stab_cnt == STAB_LAST) begin
                            state <= RUN;
                            flags <= flags_of(RUN);
                        end else begin
                            stab_cnt <= stab_cnt + CNT_ONE;
                        end
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        if (loss_cnt != 8'hFF) begin
                            loss_cnt <= loss_cnt + 8'd1;
                        end
                        retry_cnt <= '0;
                        state     <= RESET_PLL;
                        flags     <= flags_of(RESET_PLL);
                        hold_cnt  <= '0;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= IDLE;
                    flags <= flags_of(IDLE);
                end
            endcase
        end
    end

    assign bus.pll_rst   = flags[3];
    assign bus.sys_rst   = flags[2];
    assign bus.pll_ready = flags[1];
    assign bus.fault     = flags[0];
    assign bus.retry_cnt = retry_cnt;
    assign bus.loss_cnt  = loss_cnt;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters.
module tb_pll_lock_sequencer;

    logic refclk;
    logic rst;
    int   n_vec;
    int   n_err;

    pll_lock_sequencer_if bus ();

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES (4),
        .LOCK_TIMEOUT    (32),
        .LOCK_STABLE     (8),
        .MAX_RETRIES     (2),
        .CNT_W           (16)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    // flags = {pll_rst, sys_rst, pll_ready, fault}
    task automatic chk(input string tag, input logic [3:0] exp_flags,
                       input logic [3:0] exp_retry, input logic [7:0] exp_loss);
        logic [15:0] obs;
        logic [15:0] expv;
        obs  = {bus.pll_rst, bus.sys_rst, bus.pll_ready, bus.fault, bus.retry_cnt, bus.loss_cnt};
        expv = {exp_flags, exp_retry, exp_loss};
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst            = 1'b1;
        bus.enable     = 1'b0;
        bus.relock_req = 1'b0;
        bus.pll_locked = 1'b0;

        step(2);
        chk("reset", 4'b1100, 4'd0, 8'd0);

        // Bring-up
        rst = 1'b0;
        bus.enable = 1'b1;
        step(1);  chk("pulse_start", 4'b1100, 4'd0, 8'd0);
        step(3);  chk("pulse_end", 4'b1100, 4'd0, 8'd0);
        step(1);  chk("wait_lock", 4'b0100, 4'd0, 8'd0);
        step(10); bus.pll_locked = 1'b1;
        step(10); chk("stab_not_ready", 4'b0100, 4'd0, 8'd0);
        step(1);  chk("bringup_run", 4'b0010, 4'd0, 8'd0);

        // Lock loss in RUN
        bus.pll_locked = 1'b0;
        step(2);  chk("run_before_loss", 4'b0010, 4'd0, 8'd0);
        step(1);  chk("loss_reset", 4'b1100, 4'd0, 8'd1);
        step(3);  chk("loss_pulse_end", 4'b1100, 4'd0, 8'd1);
        step(1);  chk("loss_wait", 4'b0100, 4'd0, 8'd1);

        // Glitch during STABILIZE
        bus.pll_locked = 1'b1;
        step(3);  chk("relock_stab", 4'b0100, 4'd0, 8'd1);
        step(4);  bus.pll_locked = 1'b0;
        step(1);  bus.pll_locked = 1'b1;
        step(2);  chk("glitch_wait", 4'b0100, 4'd0, 8'd1);
        step(8);  chk("glitch_not_early", 4'b0100, 4'd0, 8'd1);
        step(1);  chk("glitch_run", 4'b0010, 4'd0, 8'd1);

        // Repeated losses up to saturation
        for (int i = 0; i < 254; i++) begin
            bus.pll_locked = 1'b0;
            step(1);
            bus.pll_locked = 1'b1;
            step(15);
        end
        chk("loss_255", 4'b0010, 4'd0, 8'd255);
        bus.pll_locked = 1'b0;
        step(1);  bus.pll_locked = 1'b1;
        step(2);  chk("loss_saturated", 4'b1100, 4'd0, 8'd255);
        step(13); chk("run_after_sat", 4'b0010, 4'd0, 8'd255);

        // enable dropped in STABILIZE
        bus.pll_locked = 1'b0;
        step(1);  bus.pll_locked = 1'b1;
        step(8);  chk("stab_before_disable", 4'b0100, 4'd0, 8'd255);
        bus.enable = 1'b0;
        step(1);  chk("disable_idle", 4'b1100, 4'd0, 8'd255);
        bus.enable = 1'b1;
        step(1);  chk("reenable_reset", 4'b1100, 4'd0, 8'd255);
        step(13); chk("reenable_run", 4'b0010, 4'd0, 8'd255);

        // rst in RUN
        rst = 1'b1;
        bus.pll_locked = 1'b0;
        step(1);  chk("rst_in_run", 4'b1100, 4'd0, 8'd0);
        rst = 1'b0;

        // Never locks: three attempts then FAULT
        step(4);  chk("nl_pulse0", 4'b1100, 4'd0, 8'd0);
        step(1);  chk("nl_wait0", 4'b0100, 4'd0, 8'd0);
        step(31); chk("nl_wait0_end", 4'b0100, 4'd0, 8'd0);
        step(1);  chk("nl_pulse1", 4'b1100, 4'd1, 8'd0);
        step(3);  chk("nl_pulse1_end", 4'b1100, 4'd1, 8'd0);
        step(1);  chk("nl_wait1", 4'b0100, 4'd1, 8'd0);
        step(32); chk("nl_pulse2", 4'b1100, 4'd2, 8'd0);
        step(4);  chk("nl_wait2", 4'b0100, 4'd2, 8'd0);
        step(31); chk("nl_wait2_end", 4'b0100, 4'd2, 8'd0);
        step(1);  chk("nl_fault", 4'b1101, 4'd2, 8'd0);
        step(50); chk("nl_fault_sticky", 4'b1101, 4'd2, 8'd0);

        // Recovery from FAULT
        bus.pll_locked = 1'b1;
        bus.relock_req = 1'b1;
        step(1);  bus.relock_req = 1'b0;
        chk("recover_reset", 4'b1100, 4'd0, 8'd0);
        step(4);  chk("recover_wait", 4'b0100, 4'd0, 8'd0);
        step(8);  chk("recover_not_early", 4'b0100, 4'd0, 8'd0);
        step(1);  chk("recover_run", 4'b0010, 4'd0, 8'd0);

        // relock_req in RUN restarts the sequence without counting a loss
        bus.relock_req = 1'b1;
        step(1);  bus.relock_req = 1'b0;
        chk("relock_in_run", 4'b1100, 4'd0, 8'd0);
        step(4);  chk("relock_wait", 4'b0100, 4'd0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
